// File: rtl/raster_pkg.sv
// Shared widths, VGA timing, FSM encoding and edge table
// for the raster setup controller.
package raster_pkg;

    localparam int COORD_W = 11;
    localparam int E_W     = 20;
    localparam int D_W     = COORD_W + 1;
    localparam int P_W     = 2 * COORD_W + 2;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_MUL4,
        S_MUL5,
        S_DONE
    } state_t;

    // Edge k runs from vertex EDGE_A[k] to vertex EDGE_B[k].
    localparam logic [1:0] EDGE_A [3] = '{2'd0, 2'd1, 2'd2};
    localparam logic [1:0] EDGE_B [3] = '{2'd1, 2'd2, 2'd0};

    function automatic logic [E_W-1:0] sext_d(input logic [D_W-1:0] v);
        return {{(E_W-D_W){v[D_W-1]}}, v};
    endfunction

    function automatic logic [E_W-1:0] sext_c(input logic [COORD_W-1:0] v);
        return {{(E_W-COORD_W){v[COORD_W-1]}}, v};
    endfunction

endpackage

// File: rtl/edge_setup_mac.sv
// Single shared signed multiplier feeding three per-edge
// accumulators; clr restarts the selected accumulator.
module edge_setup_mac
    import raster_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  acc_en,
    input  logic                  clr,
    input  logic                  neg,
    input  logic [1:0]            sel,
    input  logic signed [D_W-1:0] op_a,
    input  logic signed [D_W-1:0] op_b,
    output logic [2:0][E_W-1:0]   acc
);

    logic [2:0][E_W-1:0] acc_q;
    logic [2:0][E_W-1:0] acc_d;
    logic signed [P_W-1:0] prod;
    logic [E_W-1:0] term;

    // Multiply, optionally negate, and fold into the selected edge.
    always_comb begin
        prod = P_W'(op_a) * P_W'(op_b);
        term = neg ? E_W'(-prod) : E_W'(prod);
        acc_d = acc_q;
        for (int k = 0; k < 3; k++) begin
            if (acc_en && sel == 2'(k)) begin
                acc_d[k] = (clr ? '0 : acc_q[k]) + term;
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/raster_setup_ctrl.sv
// Triangle setup: edge bases via a shared MAC, shadow buffer,
// frame commit and per-line edge stepping.
module raster_setup_ctrl
    import raster_pkg::*;
#(
    parameter int COMMIT_X = H_TOTAL - 2,
    parameter int STEP_X   = H_ACTIVE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      vtx_valid,
    output logic                      vtx_ready,
    input  logic signed [COORD_W-1:0] vtx_x0,
    input  logic signed [COORD_W-1:0] vtx_y0,
    input  logic signed [COORD_W-1:0] vtx_x1,
    input  logic signed [COORD_W-1:0] vtx_y1,
    input  logic signed [COORD_W-1:0] vtx_x2,
    input  logic signed [COORD_W-1:0] vtx_y2,
    output logic [E_W-1:0]            y_screen_v0,
    output logic [E_W-1:0]            y_screen_v1,
    output logic [E_W-1:0]            y_screen_v2,
    output logic [E_W-1:0]            e0_init_t1,
    output logic [E_W-1:0]            e1_init_t1,
    output logic [E_W-1:0]            e2_init_t1,
    output logic                      setup_busy,
    output logic                      frame_commit
);

    localparam logic [9:0] CMT_X  = 10'(COMMIT_X);
    localparam logic [9:0] CMT_Y  = 10'(V_TOTAL - 1);
    localparam logic [9:0] STP_X  = 10'(STEP_X);
    localparam logic [9:0] STP_YL = 10'(V_ACTIVE - 1);

    state_t state_q, state_d;

    logic [2:0][COORD_W-1:0] vx_q, vx_d;
    logic [2:0][COORD_W-1:0] vy_q, vy_d;
    logic shadow_valid_q, shadow_valid_d;

    logic [2:0][E_W-1:0] sh_base_q, sh_base_d;
    logic [2:0][E_W-1:0] sh_step_q, sh_step_d;
    logic [2:0][E_W-1:0] sh_y_q, sh_y_d;
    logic [2:0][E_W-1:0] act_base_q, act_base_d;
    logic [2:0][E_W-1:0] act_step_q, act_step_d;
    logic [2:0][E_W-1:0] ysc_q, ysc_d;
    logic [2:0][E_W-1:0] einit_q, einit_d;

    logic hs;
    logic commit_hit;
    logic step_hit;

    logic mac_en, mac_clr, mac_neg;
    logic [1:0] mac_sel;
    logic [1:0] ia, ib;
    logic signed [COORD_W-1:0] xa, xb, ya, yb;
    logic signed [D_W-1:0] mac_a, mac_b;
    logic [2:0][E_W-1:0] mac_acc;

    assign hs         = vtx_valid && vtx_ready;
    assign commit_hit = (y == CMT_Y) && (x == CMT_X);
    assign step_hit   = (x == STP_X) && (y < STP_YL);

    edge_setup_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .acc_en (mac_en),
        .clr    (mac_clr),
        .neg    (mac_neg),
        .sel    (mac_sel),
        .op_a   (mac_a),
        .op_b   (mac_b),
        .acc    (mac_acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: six MAC slots, then one cycle to fill the shadow.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (hs) state_d = S_MUL0;
            S_MUL0: state_d = S_MUL1;
            S_MUL1: state_d = S_MUL2;
            S_MUL2: state_d = S_MUL3;
            S_MUL3: state_d = S_MUL4;
            S_MUL4: state_d = S_MUL5;
            S_MUL5: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
        endcase
    end

    // Outputs and MAC sequencing; even slot is -xa*(yb-ya),
    // odd slot adds ya*(xb-xa).
    always_comb begin
        vtx_ready    = (state_q == S_IDLE) && !shadow_valid_q;
        setup_busy   = (state_q != S_IDLE);
        frame_commit = commit_hit && shadow_valid_q;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        mac_sel = 2'd0;
        unique case (state_q)
            S_MUL0: begin mac_en = 1'b1; mac_clr = 1'b1; mac_sel = 2'd0; end
            S_MUL1: begin mac_en = 1'b1; mac_sel = 2'd0; end
            S_MUL2: begin mac_en = 1'b1; mac_clr = 1'b1; mac_sel = 2'd1; end
            S_MUL3: begin mac_en = 1'b1; mac_sel = 2'd1; end
            S_MUL4: begin mac_en = 1'b1; mac_clr = 1'b1; mac_sel = 2'd2; end
            S_MUL5: begin mac_en = 1'b1; mac_sel = 2'd2; end
            default: ;
        endcase
        mac_neg = mac_clr;
        ia = 2'd0;
        ib = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (mac_sel == 2'(k)) begin
                ia = EDGE_A[k];
                ib = EDGE_B[k];
            end
        end
        xa = vx_q[ia];
        xb = vx_q[ib];
        ya = vy_q[ia];
        yb = vy_q[ib];
        mac_a = mac_clr ? D_W'(xa) : D_W'(ya);
        mac_b = mac_clr ? (D_W'(yb) - D_W'(ya))
                        : (D_W'(xb) - D_W'(xa));
    end

    // Vertex latch, shadow fill, frame commit and line step.
    always_comb begin
        vx_d           = vx_q;
        vy_d           = vy_q;
        shadow_valid_d = shadow_valid_q;
        sh_base_d      = sh_base_q;
        sh_step_d      = sh_step_q;
        sh_y_d         = sh_y_q;
        act_base_d     = act_base_q;
        act_step_d     = act_step_q;
        ysc_d          = ysc_q;
        einit_d        = einit_q;
        if (hs) begin
            vx_d = {vtx_x2, vtx_x1, vtx_x0};
            vy_d = {vtx_y2, vtx_y1, vtx_y0};
        end
        if (state_q == S_DONE) begin
            for (int k = 0; k < 3; k++) begin
                sh_base_d[k] = mac_acc[k];
                sh_step_d[k] = sext_d(
                    D_W'(signed'(vx_q[EDGE_A[k]])) -
                    D_W'(signed'(vx_q[EDGE_B[k]])));
                sh_y_d[k] = sext_c(vy_q[k]);
            end
            shadow_valid_d = 1'b1;
        end
        // A shadow written this same cycle is left for next frame.
        if (commit_hit) begin
            if (shadow_valid_q) begin
                act_base_d     = sh_base_q;
                act_step_d     = sh_step_q;
                ysc_d          = sh_y_q;
                einit_d        = sh_base_q;
                shadow_valid_d = 1'b0;
            end else begin
                einit_d = act_base_q;
            end
        end else if (step_hit) begin
            for (int k = 0; k < 3; k++) begin
                einit_d[k] = einit_q[k] + act_step_q[k];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vx_q           <= '0;
            vy_q           <= '0;
            shadow_valid_q <= 1'b0;
            sh_base_q      <= '0;
            sh_step_q      <= '0;
            sh_y_q         <= '0;
            act_base_q     <= '0;
            act_step_q     <= '0;
            ysc_q          <= '0;
            einit_q        <= '0;
        end else begin
            vx_q           <= vx_d;
            vy_q           <= vy_d;
            shadow_valid_q <= shadow_valid_d;
            sh_base_q      <= sh_base_d;
            sh_step_q      <= sh_step_d;
            sh_y_q         <= sh_y_d;
            act_base_q     <= act_base_d;
            act_step_q     <= act_step_d;
            ysc_q          <= ysc_d;
            einit_q        <= einit_d;
        end
    end

    assign y_screen_v0 = ysc_q[0];
    assign y_screen_v1 = ysc_q[1];
    assign y_screen_v2 = ysc_q[2];
    assign e0_init_t1  = einit_q[0];
    assign e1_init_t1  = einit_q[1];
    assign e2_init_t1  = einit_q[2];

endmodule

// File: tb/tb_raster_setup_ctrl.sv
// Directed bench for raster_setup_ctrl with a triangle
// scoreboard and an edge-function reference model.
module tb_raster_setup_ctrl;

    typedef struct packed {
        logic [10:0] x0, y0, x1, y1, x2, y2;
    } tri_t;

    logic clk;
    logic reset;
    logic [9:0] x, y;
    logic vtx_valid, vtx_ready;
    logic signed [10:0] vtx_x0, vtx_y0, vtx_x1, vtx_y1, vtx_x2, vtx_y2;
    logic [19:0] y_screen_v0, y_screen_v1, y_screen_v2;
    logic [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
    logic setup_busy, frame_commit;

    int vectors = 0;
    int miscompares = 0;
    int busy_cnt = 0;
    int fc_cnt = 0;
    int hs_cnt = 0;
    logic fc, rdy, hs;
    tri_t cur, act;
    logic act_valid = 1'b0;
    tri_t q[$];
    tri_t t1, t2, t3, t4;
    int h0;

    raster_setup_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .vtx_valid    (vtx_valid),
        .vtx_ready    (vtx_ready),
        .vtx_x0       (vtx_x0),
        .vtx_y0       (vtx_y0),
        .vtx_x1       (vtx_x1),
        .vtx_y1       (vtx_y1),
        .vtx_x2       (vtx_x2),
        .vtx_y2       (vtx_y2),
        .y_screen_v0  (y_screen_v0),
        .y_screen_v1  (y_screen_v1),
        .y_screen_v2  (y_screen_v2),
        .e0_init_t1   (e0_init_t1),
        .e1_init_t1   (e1_init_t1),
        .e2_init_t1   (e2_init_t1),
        .setup_busy   (setup_busy),
        .frame_commit (frame_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tri_t mk(int a, int b, int c, int d, int e, int f);
        tri_t t;
        t.x0 = 11'(a); t.y0 = 11'(b);
        t.x1 = 11'(c); t.y1 = 11'(d);
        t.x2 = 11'(e); t.y2 = 11'(f);
        return t;
    endfunction

    function automatic int wrap20(int v);
        logic signed [19:0] w;
        w = v[19:0];
        return int'(w);
    endfunction

    function automatic int vy_of(tri_t t, int k);
        int r;
        r = (k == 0) ? int'($signed(t.y0)) :
            (k == 1) ? int'($signed(t.y1)) : int'($signed(t.y2));
        return r;
    endfunction

    function automatic int vx_of(tri_t t, int k);
        int r;
        r = (k == 0) ? int'($signed(t.x0)) :
            (k == 1) ? int'($signed(t.x1)) : int'($signed(t.x2));
        return r;
    endfunction

    // e(x,y) = (x-xa)(yb-ya) - (y-ya)(xb-xa), evaluated at x = 0.
    function automatic int model_e(tri_t t, int k, int yy);
        int a, b, xa, ya, xb, yb;
        a = k;
        b = (k + 1) % 3;
        xa = vx_of(t, a); ya = vy_of(t, a);
        xb = vx_of(t, b); yb = vy_of(t, b);
        return wrap20((0 - xa) * (yb - ya) - (yy - ya) * (xb - xa));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_e(input string tag, input int yy);
        chk({tag, ".e0"}, $signed(e0_init_t1), act_valid ? model_e(act, 0, yy) : 0);
        chk({tag, ".e1"}, $signed(e1_init_t1), act_valid ? model_e(act, 1, yy) : 0);
        chk({tag, ".e2"}, $signed(e2_init_t1), act_valid ? model_e(act, 2, yy) : 0);
    endtask

    task automatic chk_y(input string tag);
        chk({tag, ".y0"}, $signed(y_screen_v0), act_valid ? vy_of(act, 0) : 0);
        chk({tag, ".y1"}, $signed(y_screen_v1), act_valid ? vy_of(act, 1) : 0);
        chk({tag, ".y2"}, $signed(y_screen_v2), act_valid ? vy_of(act, 2) : 0);
    endtask

    task automatic offer(input tri_t t);
        cur = t;
        vtx_x0 = t.x0; vtx_y0 = t.y0;
        vtx_x1 = t.x1; vtx_y1 = t.y1;
        vtx_x2 = t.x2; vtx_y2 = t.y2;
        vtx_valid = 1'b1;
    endtask

    // One clock at pixel (xi, yi); outputs sampled 1 ns after the edge.
    task automatic cyc(input int xi, input int yi);
        x = 10'(xi);
        y = 10'(yi);
        #1;
        fc  = frame_commit;
        rdy = vtx_ready;
        hs  = vtx_valid && vtx_ready && !reset;
        if (setup_busy) busy_cnt++;
        if (fc) fc_cnt++;
        @(posedge clk);
        #1;
        if (hs) begin
            q.push_back(cur);
            hs_cnt++;
            vtx_valid = 1'b0;
        end
    endtask

    task automatic run_lines(input int lo, input int hi);
        for (int l = lo; l <= hi; l++) begin
            cyc(640, l);
            cyc(799, l);
            chk_e($sformatf("line%0d", l), (l < 479) ? l + 1 : 479);
        end
    endtask

    task automatic do_commit(input logic exp_fc);
        cyc(640, 524);
        cyc(798, 524);
        chk("commit_pulse", int'(fc), int'(exp_fc));
        if (fc) begin
            chk("shadow_depth", q.size(), 1);
            if (q.size() > 0) begin
                act = q.pop_front();
                act_valid = 1'b1;
            end
        end
        chk_e("commit", 0);
        chk_y("commit");
    endtask

    initial begin
        reset = 1'b1;
        vtx_valid = 1'b0;
        x = '0; y = '0;
        vtx_x0 = '0; vtx_y0 = '0; vtx_x1 = '0;
        vtx_y1 = '0; vtx_x2 = '0; vtx_y2 = '0;
        t1 = mk(100, 100, 200, 300, 50, 300);
        t2 = mk(-5, 0, 600, 470, 10, 400);
        t3 = mk(1000, -1000, -1000, 1000, 1023, -1024);
        t4 = mk(1, 2, 3, 4, 5, 7);

        cyc(0, 0);
        cyc(1, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(vtx_ready), 1);
        chk("rst_busy", int'(setup_busy), 0);
        chk_e("rst", 0);
        chk_y("rst");

        do_commit(1'b0);
        chk("idle_fc_total", fc_cnt, 0);

        busy_cnt = 0;
        offer(t1);
        cyc(0, 490);
        chk("t1_accept", int'(hs), 1);
        for (int i = 1; i <= 12; i++) cyc(i, 490);
        chk("busy_cycles", busy_cnt, 7);
        do_commit(1'b1);
        chk("c.e0", $signed(e0_init_t1), -10000);
        chk("c.e1", $signed(e1_init_t1), -45000);
        chk("c.e2", $signed(e2_init_t1), 25000);
        chk("c.y0", $signed(y_screen_v0), 100);
        chk("c.y1", $signed(y_screen_v1), 300);
        chk("c.y2", $signed(y_screen_v2), 300);

        run_lines(0, 0);
        chk("l0.e0", $signed(e0_init_t1), -10100);
        chk("l0.e1", $signed(e1_init_t1), -44850);
        chk("l0.e2", $signed(e2_init_t1), 24950);
        run_lines(1, 478);
        chk("l478.e0", $signed(e0_init_t1), -57900);
        chk("l478.e1", $signed(e1_init_t1), 26850);
        chk("l478.e2", $signed(e2_init_t1), 1050);
        run_lines(479, 523);
        chk("l523.e0", $signed(e0_init_t1), -57900);

        do_commit(1'b0);
        chk("redraw.e0", $signed(e0_init_t1), -10000);
        chk("redraw.e1", $signed(e1_init_t1), -45000);
        chk("redraw.e2", $signed(e2_init_t1), 25000);
        chk("fc_total", fc_cnt, 1);

        run_lines(0, 9);
        offer(t2);
        run_lines(10, 19);
        chk("t2_accept_cnt", hs_cnt, 2);
        offer(t3);
        h0 = hs_cnt;
        run_lines(20, 523);
        chk("held_ready", int'(rdy), 0);
        chk("held_no_accept", hs_cnt, h0);
        do_commit(1'b1);
        cyc(799, 524);
        chk("accept_after_commit", int'(hs), 1);

        run_lines(0, 523);
        do_commit(1'b1);
        chk("fc_total2", fc_cnt, 3);

        run_lines(0, 4);
        offer(t4);
        cyc(0, 5);
        cyc(1, 5);
        cyc(2, 5);
        cyc(3, 5);
        chk("pre_rst_busy", int'(setup_busy), 1);
        reset = 1'b1;
        cyc(4, 5);
        reset = 1'b0;
        q.delete();
        act_valid = 1'b0;
        #1;
        chk("mid_rst_busy", int'(setup_busy), 0);
        chk("mid_rst_ready", int'(vtx_ready), 1);
        chk_e("mid_rst", 0);
        chk_y("mid_rst");
        run_lines(5, 523);
        do_commit(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/raster_setup_ctrl.md
Name: raster_setup_ctrl

Overview:
- Per-frame and per-line setup controller for the edge-function rasterizer.
- Accepts one triangle (3 screen-space vertices) per frame from the vertex stage via a valid/ready handshake.
- Computes the edge-function values at pixel (0,0) using one shared, time-multiplexed multiplier.
- Double-buffers the result, commits it at the frame boundary, then steps the per-line init values every visible line so the rasterizer's line-reload at x==799 always sees the correct line-start value.

Parameters:
- COORD_W, 11, signed vertex coordinate width.
- E_W, 20, signed edge-function / y_screen output width.
- COMMIT_X, 798, pixel x of the frame commit cycle (on line V_TOTAL-1).
- STEP_X, 640, pixel x of the per-line step cycle.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- x  in  10  VGA pixel counter, 0..799.
- y  in  10  VGA line counter, 0..524.
- vtx_valid  in  1  vertex-stage triangle valid.
- vtx_ready  out  1  controller can accept a triangle.
- vtx_x0, vtx_y0, vtx_x1, vtx_y1, vtx_x2, vtx_y2  in  COORD_W each  signed vertex coordinates.
- y_screen_v0, y_screen_v1, y_screen_v2  out  E_W each  committed vertex y, sign-extended.
- e0_init_t1, e1_init_t1, e2_init_t1  out  E_W each  edge value at x=0 of the next line to be rasterized.
- setup_busy  out  1  setup sequence in progress.
- frame_commit  out  1  one-cycle pulse when a new triangle is committed.

Behaviour:
- Reset: all outputs 0 except vtx_ready; state IDLE; shadow_valid=0; base registers 0. vtx_ready is combinational: (state==IDLE) && !shadow_valid, so it is 1 in the first cycle after reset.
- Handshake: transfer when vtx_valid && vtx_ready at cycle T. Vertices latch into input registers. vtx_ready drops from T+1 until the shadow set is consumed by a commit.
- Edge k uses vertex pair (a,b): k0=(v0,v1), k1=(v1,v2), k2=(v2,v0). Edge function: e=(x-xa)(yb-ya)-(y-ya)(xb-xa).
- Setup values: base_k = -xa*(yb-ya) + ya*(xb-xa). Line step: step_k = xa-xb.
- FSM IDLE -> MUL0..MUL5 -> DONE -> IDLE:
  - MUL0..MUL5 at T+1..T+6, one product per cycle into the accumulator of the current edge.
  - DONE at T+7 writes the shadow set {base_k, step_k, y_k} and sets shadow_valid.
  - setup_busy=1 in MUL0..DONE.
- Arithmetic: differences COORD_W+1 bits; products 2*COORD_W+2 bits; sums truncated to E_W with two's-complement wrap (no saturation). y_screen outputs are vtx_y sign-extended to E_W.
- Commit, at y==524 && x==COMMIT_X:
  - If shadow_valid: active base/step/y_screen <= shadow; e*_init_t1 <= new base; shadow_valid <= 0; frame_commit=1 the same cycle.
  - Else: e*_init_t1 <= active base, so the old triangle is redrawn.
  - A shadow_valid set in the same cycle as the commit is not seen; it commits next frame.
- Line step: at x==STEP_X && y<479, e*_init_t1 <= e*_init_t1 + step_k. No step on lines 479..524.
- Outputs are stable from the commit/step cycle through the rasterizer reload at x==799.
- A handshake may occur at any y. There is at most one pending shadow set; additional triangles stall on vtx_ready.
- Reset mid-setup aborts the sequence, clears shadow_valid and returns to IDLE.

Decomposition:
- Shared package raster_pkg:
  - Width constants COORD_W, E_W.
  - VGA timing constants H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525.
  - FSM state enum.
  - Edge vertex-pair index table.
- Sub-module edge_setup_mac:
  - One signed multiplier plus accumulator with a clear/accumulate/select interface.
  - Sequenced by the FSM in raster_setup_ctrl.

Test Plan:
- Reset then idle: vtx_ready=1; all e/y outputs 0; frame_commit never pulses; at the y=524 commit, outputs reload to 0.
- Triangle v0=(100,100), v1=(200,300), v2=(50,300) accepted at y=490:
  - setup_busy high for 7 cycles.
  - At (524,798): e0/e1/e2 = -10000/-45000/25000.
  - y_screen = 100/300/300.
  - frame_commit pulses once.
- Same triangle, line stepping:
  - At (0,640): e0=-10100, e1=-44850, e2=24950.
  - At (478,640): e0=-57900, e1=26850, e2=1050.
  - Values unchanged on lines 479..524 until the next commit.
- No new triangle for the next frame: at (524,798) outputs return to -10000/-45000/25000; frame_commit stays low.
- Second triangle offered while shadow_valid: vtx_ready=0 and the triangle is held; it is accepted the cycle after the commit consumes the shadow.
- Reset asserted at MUL3: state IDLE, shadow_valid=0, outputs 0; the next commit reloads 0.
